// File: rtl/store_lane_packer.sv
// Store lane packer: narrows a 32-bit store to a word-aligned memory beat with byte enables.
// Define STORE_SPLIT_EN to split misaligned stores into two beats instead of rejecting them.
module store_lane_packer #(
    parameter int ADDR_W = 32,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              err_misalign,
    output logic              err_size,
    output logic [ADDR_W-1:0] err_addr,
    output logic [STAT_W-1:0] store_cnt
);

`ifdef STORE_SPLIT_EN
    localparam bit SPLIT_EN = 1'b1;
`else
    localparam bit SPLIT_EN = 1'b0;
`endif

    // state | meaning
    // IDLE  | waiting for a request, req_ready=1
    // BEAT1 | first (or only) write beat presented to memory
    // BEAT2 | upper-word beat of a split misaligned store
    // ERR   | one-cycle error pulse, request rejected
    typedef enum logic [1:0] {IDLE, BEAT1, BEAT2, ERR} state_t;

    state_t      state, state_nxt;
    logic        accept;
    logic [1:0]  off;
    logic [3:0]  base_mask;
    logic [6:0]  lane_mask;
    logic        misalign;
    logic        size_bad;
    logic [31:0] rot_data;
    logic [2:0]  be_hi;
    logic        split_pend;

    assign off      = req_addr[1:0];
    assign size_bad = (req_size == 2'b11);
    assign misalign = ((req_size == 2'b01) && off[0]) || ((req_size == 2'b10) && (off != 2'b00));

    always_comb begin
        base_mask = 4'b0001;
        case (req_size)
            2'b01:   base_mask = 4'b0011;
            2'b10:   base_mask = 4'b1111;
            default: base_mask = 4'b0001;
        endcase
    end

    assign lane_mask = {3'b000, base_mask} << off;

    always_comb begin
        rot_data = req_data;
        case (off)
            2'd1:    rot_data = {req_data[23:0], req_data[31:24]};
            2'd2:    rot_data = {req_data[15:0], req_data[31:16]};
            2'd3:    rot_data = {req_data[7:0],  req_data[31:8]};
            default: rot_data = req_data;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        req_ready = 1'b0;
        accept    = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                accept    = req_valid;
                if (req_valid) begin
                    if (size_bad || (misalign && !SPLIT_EN)) state_nxt = ERR;
                    else                                     state_nxt = BEAT1;
                end
            end
            BEAT1:   if (mem_ready) state_nxt = split_pend ? BEAT2 : IDLE;
            BEAT2:   if (mem_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_valid    <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            mem_be       <= '0;
            be_hi        <= '0;
            split_pend   <= 1'b0;
            err_misalign <= 1'b0;
            err_size     <= 1'b0;
            err_addr     <= '0;
            store_cnt    <= '0;
        end else begin
            err_misalign <= 1'b0;
            err_size     <= 1'b0;
            if (accept) begin
                if (size_bad) begin
                    err_size <= 1'b1;
                    err_addr <= req_addr;
                end else if (misalign && !SPLIT_EN) begin
                    err_misalign <= 1'b1;
                    err_addr     <= req_addr;
                end else begin
                    mem_valid  <= 1'b1;
                    mem_addr   <= {req_addr[ADDR_W-1:2], 2'b00};
                    mem_wdata  <= rot_data;
                    mem_be     <= lane_mask[3:0];
                    be_hi      <= lane_mask[6:4];
                    split_pend <= misalign;
                end
            end else if ((state == BEAT1 || state == BEAT2) && mem_ready) begin
                if (state == BEAT1 && split_pend) begin
                    // Second beat keeps the rotated data; only the word and lanes move.
                    mem_addr   <= mem_addr + ADDR_W'(4);
                    mem_be     <= {1'b0, be_hi};
                    split_pend <= 1'b0;
                end else begin
                    mem_valid <= 1'b0;
                    if (store_cnt != {STAT_W{1'b1}}) store_cnt <= store_cnt + 1'b1;
                end
            end
        end
    end

endmodule
